// File: rtl/glitch_pkg.sv
// Shared types and default widths for the clock-glitch burst generator.
package glitch_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int NUM_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_GLITCH,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        FORCE_HI = 2'd0,
        FORCE_LO = 2'd1,
        INVERT   = 2'd2
    } mode_t;

    // Encoding 3 is unnamed and behaves as FORCE_HI.
    function automatic logic apply_mode(input logic [1:0] mode, input logic clean);
        logic result;
        case (mode)
            2'(FORCE_LO): result = 1'b0;
            2'(INVERT):   result = ~clean;
            default:      result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/glitch_clk_burst_if.sv
// Control, configuration and status bundle of the glitch burst generator.
interface glitch_clk_burst_if
    import glitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
);
    logic             clean_target_clock;
    logic             trig;
    logic             arm;
    logic             abort;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [NUM_W-1:0] cfg_count;
    logic [1:0]       cfg_mode;
    logic             cfg_rearm;
    logic             clk_o;
    logic             busy;
    logic             armed;
    logic             done;

    modport master (
        output clean_target_clock, trig, arm, abort,
        output cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode, cfg_rearm,
        input  clk_o, busy, armed, done
    );

    modport slave (
        input  clean_target_clock, trig, arm, abort,
        input  cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode, cfg_rearm,
        output clk_o, busy, armed, done
    );

endinterface

// File: rtl/glitch_timer.sv
// Loadable down-counter with zero flag; shared by the DELAY, GLITCH and GAP phases.
module glitch_timer
    import glitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/glitch_clk_burst.sv
// Triggered clock-glitch burst generator: delay, then count glitches of width
// cycles separated by gap cycles, applied to a clean target clock.
module glitch_clk_burst
    import glitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    glitch_clk_burst_if.slave   bus
);

    state_t           state;
    logic             trig_q;
    logic             fire_q;
    logic             glitch_active;
    logic             busy_q;
    logic             armed_q;
    logic             done_q;

    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [NUM_W-1:0] count_q;
    logic [NUM_W-1:0] remaining;
    logic [1:0]       mode_q;
    logic             rearm_q;

    logic             trig_edge;
    logic [CNT_W-1:0] delay_m1;
    logic [CNT_W-1:0] width_m1;
    logic [CNT_W-1:0] gap_m1;
    logic [NUM_W-1:0] count_eff;
    logic             last;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;

    assign trig_edge = bus.trig & ~trig_q;
    assign delay_m1  = delay_q - CNT_W'(1);
    assign width_m1  = (width_q == '0) ? '0 : width_q - CNT_W'(1);
    assign gap_m1    = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
    assign count_eff = (count_q == '0) ? NUM_W'(1) : count_q;
    assign last      = (remaining <= NUM_W'(1));

    glitch_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // The timer is reloaded on every phase entry with the phase length minus one.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            ST_ARMED: begin
                if (fire_q) begin
                    timer_load = 1'b1;
                    timer_val  = (delay_q == '0) ? width_m1 : delay_m1;
                end
            end
            ST_DELAY, ST_GAP: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = width_m1;
                end
            end
            ST_GLITCH: begin
                if (timer_zero && !last) begin
                    timer_load = 1'b1;
                    timer_val  = gap_m1;
                end
            end
            default: ;
        endcase
    end

    // fire_q registers an accepted trigger edge so the first glitch starts
    // 1+delay cycles after the edge, including the delay==0 case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            trig_q        <= 1'b0;
            fire_q        <= 1'b0;
            glitch_active <= 1'b0;
            busy_q        <= 1'b0;
            armed_q       <= 1'b0;
            done_q        <= 1'b0;
            delay_q       <= '0;
            width_q       <= '0;
            gap_q         <= '0;
            count_q       <= '0;
            remaining     <= '0;
            mode_q        <= '0;
            rearm_q       <= 1'b0;
        end else begin
            trig_q <= bus.trig;
            done_q <= 1'b0;
            fire_q <= trig_edge && (state == ST_ARMED) && !bus.abort;
            if (bus.abort) begin
                state         <= ST_IDLE;
                fire_q        <= 1'b0;
                glitch_active <= 1'b0;
                busy_q        <= 1'b0;
                armed_q       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.arm) begin
                            delay_q <= bus.cfg_delay;
                            width_q <= bus.cfg_width;
                            gap_q   <= bus.cfg_gap;
                            count_q <= bus.cfg_count;
                            mode_q  <= bus.cfg_mode;
                            rearm_q <= bus.cfg_rearm;
                            state   <= ST_ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (fire_q) begin
                            remaining <= count_eff;
                            armed_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            if (delay_q == '0) begin
                                state         <= ST_GLITCH;
                                glitch_active <= 1'b1;
                            end else begin
                                state <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY, ST_GAP: begin
                        if (timer_zero) begin
                            state         <= ST_GLITCH;
                            glitch_active <= 1'b1;
                        end
                    end
                    ST_GLITCH: begin
                        if (timer_zero) begin
                            glitch_active <= 1'b0;
                            remaining     <= remaining - NUM_W'(1);
                            if (last) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                armed_q <= rearm_q;
                                state   <= rearm_q ? ST_ARMED : ST_IDLE;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                    default: begin
                        state         <= ST_IDLE;
                        glitch_active <= 1'b0;
                        busy_q        <= 1'b0;
                        armed_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.clk_o = glitch_active ? apply_mode(mode_q, bus.clean_target_clock)
                                     : bus.clean_target_clock;
    assign bus.busy  = busy_q;
    assign bus.armed = armed_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_glitch_clk_burst.sv
// Directed bench for glitch_clk_burst: per-cycle vector table plus long-width
// and reset-during-glitch sequences.
module tb_glitch_clk_burst;

    logic clk;
    logic rst;

    glitch_clk_burst_if #(.CNT_W(16), .NUM_W(8)) bus ();

    glitch_clk_burst #(.CNT_W(16), .NUM_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clk period 10 units, clean target clock period 40 units (4 clk cycles).
    initial clk = 1'b1;
    always #5 clk = ~clk;
    initial bus.clean_target_clock = 1'b0;
    always #20 bus.clean_target_clock = ~bus.clean_target_clock;

    typedef struct {
        logic        arm;
        logic        trig;
        logic        abort;
        logic        rearm;
        logic [15:0] d;
        logic [15:0] w;
        logic [15:0] g;
        logic [7:0]  c;
        logic [1:0]  m;
        logic        eb;
        logic        ea;
        logic        ed;
        logic        eg;
        logic [1:0]  xm;
    } vec_t;

    vec_t        tv[$];
    int unsigned n_pass;
    int unsigned n_total;
    logic [1:0]  tbl_mode;
    bit          prev_idle;

    function automatic logic xform(input logic act, input logic [1:0] m, input logic c);
        logic r;
        if (!act)          r = c;
        else if (m == 2'd1) r = 1'b0;
        else if (m == 2'd2) r = ~c;
        else               r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic A(input int d, input int w, input int g, input int c, input int m,
                     input bit rearm, input bit trig, input bit abort,
                     input bit eb, input bit ea, input bit ed, input bit eg);
        vec_t v;
        v.arm = 1'b1; v.trig = trig; v.abort = abort; v.rearm = rearm;
        v.d = 16'(d); v.w = 16'(w); v.g = 16'(g); v.c = 8'(c); v.m = 2'(m);
        v.eb = eb; v.ea = ea; v.ed = ed; v.eg = eg;
        if (prev_idle && !abort) tbl_mode = 2'(m);
        v.xm = tbl_mode;
        prev_idle = !ea && !eb;
        tv.push_back(v);
    endtask

    // Non-arm cycle: cfg bus carries unrelated values that must not be latched.
    task automatic S(input bit trig, input bit abort,
                     input bit eb, input bit ea, input bit ed, input bit eg);
        vec_t v;
        v.arm = 1'b0; v.trig = trig; v.abort = abort; v.rearm = 1'b1;
        v.d = 16'd7; v.w = 16'd9; v.g = 16'd5; v.c = 8'd4; v.m = 2'd2;
        v.eb = eb; v.ea = ea; v.ed = ed; v.eg = eg;
        v.xm = tbl_mode;
        prev_idle = !ea && !eb;
        tv.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.arm       = v.arm;
        bus.trig      = v.trig;
        bus.abort     = v.abort;
        bus.cfg_rearm = v.rearm;
        bus.cfg_delay = v.d;
        bus.cfg_width = v.w;
        bus.cfg_gap   = v.g;
        bus.cfg_count = v.c;
        bus.cfg_mode  = v.m;
    endtask

    task automatic drive_cfg(input int d, input int w, input int c, input int m);
        bus.cfg_delay = 16'(d);
        bus.cfg_width = 16'(w);
        bus.cfg_gap   = 16'd1;
        bus.cfg_count = 8'(c);
        bus.cfg_mode  = 2'(m);
        bus.cfg_rearm = 1'b0;
    endtask

    initial begin
        int unsigned gl;
        bit seen;
        n_pass = 0; n_total = 0; tbl_mode = 2'd0; prev_idle = 1'b1;
        rst = 1'b1;
        bus.arm = 1'b0; bus.trig = 1'b0; bus.abort = 1'b0;
        drive_cfg(0, 0, 0, 0);

        // Outputs inert while reset is held.
        repeat (7) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", {29'd0, bus.busy, bus.armed, bus.done}, 32'd0);
            chk("reset_clk_o", {31'd0, bus.clk_o}, {31'd0, bus.clean_target_clock});
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", {29'd0, bus.busy, bus.armed, bus.done}, 32'd0);

        // Single glitch: delay 3, width 2, mode force-high; trig rises at t=115.
        A(3, 2, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(1, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 0, 0, 1, 0);
        S(0, 0, 0, 0, 0, 0);
        // Burst: delay 0, width 1, gap 2, count 3, invert.
        A(0, 1, 2, 3, 2, 0, 0, 0,  0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 0, 0, 1, 0);
        S(0, 0, 0, 0, 0, 0);
        // Rearm: two triggers 5 cycles apart, third edge during last glitch cycle.
        A(1, 1, 0, 1, 1, 1, 0, 0,  0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 0, 1, 1, 0);
        S(0, 0, 0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(1, 0, 0, 1, 1, 0);
        S(0, 0, 0, 1, 0, 0);
        S(0, 0, 0, 1, 0, 0);
        S(0, 1, 0, 0, 0, 0);
        // Abort during GAP of a count=3 burst.
        A(0, 1, 3, 3, 0, 0, 0, 0,  0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 1, 0, 0, 0);
        S(0, 1, 0, 0, 0, 0);
        S(0, 0, 0, 0, 0, 0);
        S(1, 0, 0, 0, 0, 0);
        S(0, 0, 0, 0, 0, 0);
        S(0, 0, 0, 0, 0, 0);
        S(0, 0, 0, 0, 0, 0);
        // Zero width/gap/count behave as 1; delay 2, force-low.
        A(2, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(1, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 0);
        S(0, 0, 1, 0, 0, 1);
        S(0, 0, 0, 0, 1, 0);
        S(0, 0, 0, 0, 0, 0);
        // abort beats arm; arm+trig edge only arms; arm outside IDLE ignored.
        A(1, 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
        A(1, 1, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        S(0, 0, 0, 1, 0, 0);
        S(1, 0, 0, 1, 0, 0);
        A(0, 3, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0);
        A(0, 3, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1);
        S(0, 0, 0, 0, 1, 0);
        S(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {28'd0, bus.busy, bus.armed, bus.done, bus.clk_o},
                {28'd0, tv[i].eb, tv[i].ea, tv[i].ed,
                 xform(tv[i].eg, tv[i].xm, bus.clean_target_clock)});
        end
        bus.arm = 1'b0; bus.trig = 1'b0; bus.abort = 1'b0;

        // Maximum width: invert mode, clk_o differs from clean exactly while glitching.
        drive_cfg(0, 65535, 1, 2);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        gl = 0;
        seen = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (bus.clk_o !== bus.clean_target_clock) gl++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("maxw_done_seen", {31'd0, seen}, 32'd1);
        chk("maxw_cycles", gl, 32'd65535);
        @(negedge clk);
        chk("maxw_idle", {29'd0, bus.busy, bus.armed, bus.done}, 32'd0);

        // Reset asserted mid-glitch in force-low mode.
        drive_cfg(0, 40, 1, 1);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.clean_target_clock === 1'b1) break;
        end
        chk("lo_glitch_clk_o", {31'd0, bus.clk_o}, 32'd0);
        chk("lo_glitch_clean", {31'd0, bus.clean_target_clock}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_clk_o", {31'd0, bus.clk_o}, {31'd0, bus.clean_target_clock});
        chk("rst_async_outs", {29'd0, bus.busy, bus.armed, bus.done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_rst_outs", {29'd0, bus.busy, bus.armed, bus.done}, 32'd0);
            chk("after_rst_clk_o", {31'd0, bus.clk_o}, {31'd0, bus.clean_target_clock});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
